// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: decides the branch outcome, trains a 2-bit BHT and issues registered redirects.
// Optional BRANCH_STATS_EN adds branch/jump/mispredict event counters.
module branch_resolve #(
    parameter int         BHT_IDX_W = 6,
    parameter logic [1:0] RESET_CTR = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic        sign_select,
    input  logic        equal,
    input  logic        less_than,
`ifdef BRANCH_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_jumps,
    output logic [31:0] stat_mispredicts,
`endif
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    logic [BHT_N-1:0][1:0] bht;
    logic [BHT_IDX_W-1:0]  if_idx;
    logic [BHT_IDX_W-1:0]  ex_idx;
    logic                  res;
    logic                  cond;
    logic                  taken;
    logic                  mispredict;
    logic                  train;
    logic [1:0]            ctr;
    logic [1:0]            ctr_next;

    // Only the word-index bits of the fetch PC address the table.
    logic unused_if_pc;
    assign unused_if_pc = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

    assign if_idx        = if_pc[BHT_IDX_W+1:2];
    assign ex_idx        = ex_pc[BHT_IDX_W+1:2];
    assign if_pred_taken = bht[if_idx][1];
    assign sign_select   = ex_funct3[1];

    // The instruction in EX during a redirect pulse is wrong-path.
    assign res        = ex_valid & ~ex_stall & ~redirect_valid & (ex_branch | ex_jump);
    assign taken      = ex_jump | cond;
    assign mispredict = res & (taken != ex_pred_taken);
    assign train      = res & ex_branch;
    assign ctr        = bht[ex_idx];

    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:          cond = equal;
            3'b001:          cond = ~equal;
            3'b100, 3'b110:  cond = less_than;
            3'b101, 3'b111:  cond = ~less_than;
            default:         cond = 1'b0;
        endcase
    end

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != 2'b11) ctr_next = ctr + 2'd1;
        end else if (ctr != 2'b00) begin
            ctr_next = ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            bht            <= {BHT_N{RESET_CTR}};
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) redirect_pc <= taken ? ex_target : ex_pc + 32'd4;
            if (train) bht[ex_idx] <= ctr_next;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_jumps       <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (res & ex_branch) stat_branches    <= stat_branches + 32'd1;
            if (res & ex_jump)   stat_jumps       <= stat_jumps + 32'd1;
            if (mispredict)      stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: decode vector table plus hand sequences for
// back-to-back redirects, same-cycle lookup/train, stall, reset and optional stats.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_stall, ex_branch, ex_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_target;
    logic        ex_pred_taken;
    logic        sign_select;
    logic        equal, less_than;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_jumps, stat_mispredicts;
`endif

    int errors = 0;
    int checks = 0;

    branch_resolve dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .sign_select(sign_select),
        .equal(equal), .less_than(less_than),
`ifdef BRANCH_STATS_EN
        .stat_branches(stat_branches), .stat_jumps(stat_jumps),
        .stat_mispredicts(stat_mispredicts),
`endif
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic        jp;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
        logic        eq;
        logic        lt;
        logic        exp_rv;
        logic [31:0] exp_pc;
        logic        exp_ss;
    } vec_t;

    vec_t        vt[12];
    logic [31:0] pchk_pc[10];
    logic        pchk_exp[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic jp, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic eq, input logic lt);
        ex_valid = 1'b1; ex_branch = br; ex_jump = jp; ex_funct3 = f3;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; equal = eq; less_than = lt;
    endtask

    // One resolution cycle followed by an idle cycle so the next one is not shadowed.
    task automatic issue(input string nm, input logic br, input logic jp, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic eq, input logic lt,
                         input logic exp_rv, input logic [31:0] exp_pc);
        drive(br, jp, f3, pc, tgt, pred, eq, lt);
        tick();
        ex_valid = 1'b0;
        check({nm, ".rv"}, {31'd0, redirect_valid}, {31'd0, exp_rv});
        if (exp_rv) check({nm, ".pc"}, redirect_pc, exp_pc);
        tick();
        check({nm, ".rv_clr"}, {31'd0, redirect_valid}, 32'd0);
    endtask

    task automatic pred_at(input string nm, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(nm, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 3'b000, 32'h100,      32'h140,  1'b0, 1'b1, 1'b0, 1'b1, 32'h140,  1'b0};
        vt[1]  = '{1'b1, 1'b0, 3'b001, 32'h304,      32'h999,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0};
        vt[2]  = '{1'b1, 1'b0, 3'b100, 32'h408,      32'h500,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0};
        vt[3]  = '{1'b1, 1'b0, 3'b101, 32'h40C,      32'h500,  1'b1, 1'b0, 1'b1, 1'b1, 32'h410,  1'b0};
        vt[4]  = '{1'b1, 1'b0, 3'b111, 32'h410,      32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 3'b010, 32'h414,      32'h700,  1'b1, 1'b1, 1'b1, 1'b1, 32'h418,  1'b1};
        vt[6]  = '{1'b1, 1'b0, 3'b011, 32'h418,      32'h700,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    1'b1};
        vt[7]  = '{1'b0, 1'b1, 3'b000, 32'h41C,      32'h8,    1'b0, 1'b0, 1'b0, 1'b1, 32'h8,    1'b0};
        vt[8]  = '{1'b1, 1'b1, 3'b000, 32'h420,      32'h900,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0};
        vt[9]  = '{1'b1, 1'b0, 3'b000, 32'hFFFFFFFC, 32'h40,   1'b1, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0};
        vt[10] = '{1'b1, 1'b0, 3'b110, 32'h428,      32'h80,   1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    1'b1};
        vt[11] = '{1'b1, 1'b0, 3'b001, 32'h42C,      32'h3000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 1'b0};

        // Counter state after the table, starting from 01 everywhere.
        pchk_pc = '{32'h100, 32'h304, 32'h408, 32'h40C, 32'h410,
                    32'h41C, 32'h420, 32'hFFFFFFFC, 32'h428, 32'h42C};
        pchk_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; if_pc = '0; ex_stall = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        ex_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset.rv", {31'd0, redirect_valid}, 32'd0);
        check("reset.pc", redirect_pc, 32'd0);
        pred_at("reset.pred0",   32'h0,   1'b0);
        pred_at("reset.pred100", 32'h100, 1'b0);
        pred_at("reset.predFC",  32'hFC,  1'b0);

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].br, vt[i].jp, vt[i].f3, vt[i].pc, vt[i].tgt, vt[i].pred, vt[i].eq, vt[i].lt);
            #1;
            check($sformatf("vec%0d.ss", i), {31'd0, sign_select}, {31'd0, vt[i].exp_ss});
            issue($sformatf("vec%0d", i), vt[i].br, vt[i].jp, vt[i].f3, vt[i].pc, vt[i].tgt,
                  vt[i].pred, vt[i].eq, vt[i].lt, vt[i].exp_rv, vt[i].exp_pc);
        end
        for (int i = 0; i < 10; i++)
            pred_at($sformatf("bht%0d", i), pchk_pc[i], pchk_exp[i]);

        // BLTU not taken three times drives index 0 from 10 down to 00 and holds there.
        for (int i = 0; i < 3; i++)
            issue($sformatf("bltu%0d", i), 1'b1, 1'b0, 3'b110, 32'h200, 32'h600,
                  1'b1, 1'b0, 1'b0, 1'b1, 32'h204);
        pred_at("bltu.pred", 32'h200, 1'b0);
        issue("beq_after_floor", 1'b1, 1'b0, 3'b000, 32'h200, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        pred_at("floor.pred", 32'h200, 1'b0);

        // Back-to-back mispredicts: the second is shadowed by the first redirect.
        drive(1'b1, 1'b0, 3'b000, 32'h504, 32'h600, 1'b0, 1'b1, 1'b0);
        tick();
        check("b2b.rv1", {31'd0, redirect_valid}, 32'd1);
        check("b2b.pc1", redirect_pc, 32'h600);
        drive(1'b1, 1'b0, 3'b001, 32'h508, 32'h700, 1'b1, 1'b1, 1'b0);
        tick();
        ex_valid = 1'b0;
        check("b2b.rv2", {31'd0, redirect_valid}, 32'd0);
        check("b2b.pc_hold", redirect_pc, 32'h600);
        pred_at("b2b.untrained", 32'h508, 1'b1);

        // Stalled or invalid EX never redirects.
        ex_stall = 1'b1;
        issue("jal_stall", 1'b0, 1'b1, 3'b000, 32'h41C, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        ex_stall = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
        ex_valid = 1'b0;
        tick();
        check("invalid.rv", {31'd0, redirect_valid}, 32'd0);

        // Reset wins over a pending mispredict.
        drive(1'b1, 1'b0, 3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_valid = 1'b0;
        check("rstmid.rv", {31'd0, redirect_valid}, 32'd0);
        check("rstmid.pc", redirect_pc, 32'd0);
        tick();
        check("rstmid.rv_after", {31'd0, redirect_valid}, 32'd0);
        pred_at("rstmid.bht", 32'h408, 1'b0);
`ifdef BRANCH_STATS_EN
        check("stats.br_clr", stat_branches, 32'd0);
        check("stats.jp_clr", stat_jumps, 32'd0);
        check("stats.mp_clr", stat_mispredicts, 32'd0);
`endif

        // Same-cycle lookup and train at index 5: fetch sees the old counter.
        if_pc = 32'h14;
        drive(1'b1, 1'b0, 3'b000, 32'h14, 32'h80, 1'b0, 1'b1, 1'b0);
        #1;
        check("bypass.old", {31'd0, if_pred_taken}, 32'd0);
        tick();
        ex_valid = 1'b0;
        check("bypass.new", {31'd0, if_pred_taken}, 32'd1);
        check("bypass.rv", {31'd0, redirect_valid}, 32'd1);
        check("bypass.pc", redirect_pc, 32'h80);
        tick();

        issue("wrap", 1'b1, 1'b0, 3'b000, 32'hFFFFFFFC, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
`ifdef BRANCH_STATS_EN
        check("stats.br", stat_branches, 32'd2);
        check("stats.jp", stat_jumps, 32'd0);
        check("stats.mp", stat_mispredicts, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage branch resolution unit, directly downstream of the branch comparator.
- Consumes the comparator's equal/less_than flags plus the EX-stage instruction's branch/jump info and decides the actual branch outcome.
- Compares that outcome with the fetch-time prediction and issues a registered redirect/flush to fetch.
- Owns the direction predictor, a table of 2-bit saturating counters that fetch reads and this block trains.

Parameters:
- BHT_IDX_W, 6: log2 of predictor entries (64 entries); index = pc[BHT_IDX_W+1:2].
- RESET_CTR, 2'b01: counter value loaded into every entry on reset (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  32  fetch PC for prediction lookup.
- if_pred_taken  out  1  combinational prediction: selected counter[1].
- ex_valid  in  1  EX-stage holds a real instruction.
- ex_stall  in  1  EX-stage is frozen this cycle; no resolution or training.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_jump  in  1  EX instruction is JAL/JALR.
- ex_funct3  in  3  branch funct3.
- ex_pc  in  32  EX instruction PC.
- ex_target  in  32  computed taken target; JALR LSB is already cleared upstream.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- sign_select  out  1  to comparator: 1 = unsigned, 0 = signed; equals ex_funct3[1].
- equal  in  1  from comparator.
- less_than  in  1  from comparator.
- redirect_valid  out  1  registered one-cycle pulse: flush younger stages, load redirect_pc.
- redirect_pc  out  32  registered corrected PC.

Behaviour:
- Resolve condition: res = ex_valid & ~ex_stall & ~redirect_valid & (ex_branch | ex_jump).
  - While redirect_valid is high, the EX instruction is wrong-path and is ignored entirely: no redirect and no training.
- Taken decode, by funct3:
  - 000 BEQ = equal.
  - 001 BNE = ~equal.
  - 100 BLT and 110 BLTU = less_than.
  - 101 BGE and 111 BGEU = ~less_than.
  - 010 and 011 = not taken.
- ex_jump forces taken = 1. If ex_jump and ex_branch are both high, jump wins.
- Mispredict = res & (taken != ex_pred_taken).
- Redirect timing: on mispredict, at the next clk edge redirect_valid <= 1 and redirect_pc <= taken ? ex_target : ex_pc + 4 (wraps mod 2^32).
- Otherwise redirect_valid <= 0 and redirect_pc holds its last value. redirect_valid is never high for 2 consecutive cycles.
- Training: on res & ex_branch only (jumps do not train), the counter at ex_pc's index saturates.
  - Taken: +1, capped at 11.
  - Not taken: -1, floored at 00.
  - The write happens at the clk edge.
- Lookup: if_pred_taken reads the table combinationally with read-before-write semantics. When the fetch index equals the index being trained in the same cycle, fetch sees the old counter value.
- Reset: redirect_valid = 0, redirect_pc = 0, every counter = RESET_CTR. With the default RESET_CTR, if_pred_taken = 0 everywhere after reset.
- Reset mid-operation: rst has priority over a pending mispredict; no redirect pulse follows reset.
- sign_select is purely combinational from ex_funct3 and is valid regardless of ex_valid.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, add three outputs:
  - stat_branches (32): count of res & ex_branch.
  - stat_jumps (32): count of res & ex_jump.
  - stat_mispredicts (32): count of mispredicts.
- All three counters clear on rst and wrap at 2^32.
- When undefined, these ports and registers are absent and the behaviour above is unchanged.

Test Plan:
- Reset then BEQ at ex_pc=0x100, equal=1, ex_pred_taken=0, target=0x140 -> next cycle redirect_valid=1, redirect_pc=0x140; counter[0x100] goes 01->10, so a later if_pc=0x100 gives if_pred_taken=1.
- BLTU: ex_funct3=110 -> sign_select=1; less_than=0, ex_pred_taken=1, ex_pc=0x200 -> redirect_pc=0x204; counter at 0x200 saturates at 00 after 3 repeats.
- Back-to-back: mispredicting branch in cycle N, another mispredicting branch in cycle N+1 -> only one redirect pulse (N+1); the second branch is not trained.
- Same-cycle lookup/train at index 5 with counter=01 and taken -> if_pred_taken=0 that cycle, 1 the next.
- JAL with ex_pred_taken=0, target=0x8 -> redirect_pc=0x8, table unchanged; ex_stall=1 with the same inputs -> no redirect.
- ex_pc=0xFFFFFFFC, not taken, predicted taken -> redirect_pc=0x00000000. With BRANCH_STATS_EN: stat_mispredicts increments by 1; rst mid-run clears all stats.
